// File: rtl/fetch_unit_if.sv
// IF/ID bus between the fetch stage and decode: pipeline control flows in,
// the registered instruction bundle flows out.
interface fetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
);
  logic                  stall;
  logic                  flush;
  logic                  redirect_valid;
  logic [ADDR_W-1:0]     redirect_pc;
  logic                  if_valid;
  logic [2*DATA_W-1:0]   if_instr;
  logic                  if_is_long;
  logic [ADDR_W-1:0]     if_pc;
  logic [ADDR_W-1:0]     if_pc_next;

  modport master (
    input  stall, flush, redirect_valid, redirect_pc,
    output if_valid, if_instr, if_is_long, if_pc, if_pc_next
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_is_long, if_pc, if_pc_next
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and instruction memory, boots from a
// memory-held reset vector, joins two-word instructions and vectors to
// interrupt handlers. All IF/ID outputs are registered.
module fetch_unit #(
  parameter int               DATA_W         = 16,
  parameter int               ADDR_W         = 32,
  parameter int               DEPTH_LOG2     = 19,
  parameter int               RESET_VEC_ADDR = 0,
  parameter int               INT_VEC_BASE   = 2,
  parameter int               N_INT          = 2,
  parameter logic [DATA_W-1:0] NOP           = 16'h4000,
  parameter logic [1:0]       LONG_TAG       = 2'b11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_we,
  input  logic [DEPTH_LOG2-1:0] imem_waddr,
  input  logic [DATA_W-1:0]     imem_wdata,
  input  logic [N_INT-1:0]      int_req,
  output logic [N_INT-1:0]      int_ack,
  output logic [ADDR_W-1:0]     epc,
  fetch_unit_if.master          fb
);

  localparam int IDX_W = (N_INT > 1) ? $clog2(N_INT) : 1;
  localparam logic [DEPTH_LOG2-1:0] RST_A = DEPTH_LOG2'(RESET_VEC_ADDR);
  localparam logic [DEPTH_LOG2-1:0] INT_A = DEPTH_LOG2'(INT_VEC_BASE);

  typedef enum logic [1:0] {BOOT, RUN, IMM, INT} state_e;

  typedef struct packed {
    logic                valid;
    logic [2*DATA_W-1:0] instr;
    logic                is_long;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_next;
  } if_out_t;

  localparam if_out_t OUT_RST = '{valid: 1'b0, instr: {NOP, {DATA_W{1'b0}}},
                                  is_long: 1'b0, pc: '0, pc_next: '0};

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [IDX_W-1:0]  int_idx_q, int_idx_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [N_INT-1:0]  int_ack_q, int_ack_d;
  if_out_t           out_q, out_d;

  logic [DATA_W-1:0]     word;
  logic [ADDR_W-1:0]     pc_inc;
  logic [DEPTH_LOG2-1:0] vec_a0;
  logic [2*DATA_W-1:0]   vec_raw;
  logic [ADDR_W-1:0]     pc_vec;
  logic [IDX_W-1:0]      int_sel;
  logic                  is_long_word;

  // Program load port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  // Fetch word, vector word pair (reset or selected interrupt) and lowest-index request.
  always_comb begin
    word         = mem[pc_q[DEPTH_LOG2-1:0]];
    pc_inc       = pc_q + ADDR_W'(1);
    is_long_word = (word[DATA_W-1 -: 2] == LONG_TAG);
    vec_a0       = (state_q == BOOT) ? RST_A
                                     : INT_A + DEPTH_LOG2'({int_idx_q, 1'b0});
    vec_raw      = {mem[vec_a0], mem[vec_a0 + DEPTH_LOG2'(1)]};
    pc_vec       = ADDR_W'(vec_raw);
    int_sel      = '0;
    for (int i = N_INT - 1; i >= 0; i--)
      if (int_req[i]) int_sel = IDX_W'(i);
  end

  // Next-state: redirect > flush > stall > interrupt > normal fetch.
  always_comb begin
    if_out_t bub;
    bub         = out_q;
    bub.valid   = 1'b0;
    bub.instr   = {NOP, {DATA_W{1'b0}}};
    bub.is_long = 1'b0;

    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    int_idx_d = int_idx_q;
    epc_d     = epc_q;
    int_ack_d = '0;
    out_d     = out_q;

    if (fb.redirect_valid) begin
      pc_d    = fb.redirect_pc;
      state_d = RUN;
      out_d   = bub;
    end else if (fb.flush) begin
      out_d = bub;
      case (state_q)
        IMM: begin
          pc_d    = hold_pc_q;   // refetch the whole long instruction
          state_d = RUN;
        end
        BOOT, INT: begin         // vector load is not squashable
          pc_d    = pc_vec;
          state_d = RUN;
        end
        default: ;
      endcase
    end else if (!fb.stall) begin
      case (state_q)
        BOOT, INT: begin
          pc_d    = pc_vec;
          state_d = RUN;
          out_d   = bub;
        end
        RUN: begin
          if (|int_req) begin
            int_ack_d = N_INT'(1) << int_sel;
            int_idx_d = int_sel;
            epc_d     = pc_q;
            state_d   = INT;
            out_d     = bub;
          end else if (is_long_word) begin
            hold_d    = word;
            hold_pc_d = pc_q;
            pc_d      = pc_inc;
            state_d   = IMM;
            out_d     = bub;
          end else begin
            out_d.valid   = 1'b1;
            out_d.instr   = {word, {DATA_W{1'b0}}};
            out_d.is_long = 1'b0;
            out_d.pc      = pc_q;
            out_d.pc_next = pc_inc;
            pc_d          = pc_inc;
          end
        end
        IMM: begin
          out_d.valid   = 1'b1;
          out_d.instr   = {hold_q, word};
          out_d.is_long = 1'b1;
          out_d.pc      = hold_pc_q;
          out_d.pc_next = pc_inc;
          pc_d          = pc_inc;
          state_d       = RUN;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= '0;
      hold_q    <= '0;
      hold_pc_q <= '0;
      int_idx_q <= '0;
      epc_q     <= '0;
      int_ack_q <= '0;
      out_q     <= OUT_RST;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      int_idx_q <= int_idx_d;
      epc_q     <= epc_d;
      int_ack_q <= int_ack_d;
      out_q     <= out_d;
    end
  end

  assign int_ack       = int_ack_q;
  assign epc           = epc_q;
  assign fb.if_valid   = out_q.valid;
  assign fb.if_instr   = out_q.instr;
  assign fb.if_is_long = out_q.is_long;
  assign fb.if_pc      = out_q.pc;
  assign fb.if_pc_next = out_q.pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, long instructions, stall/flush/redirect
// priority, interrupts, PC wrap and asynchronous reset mid-instruction.
module tb_fetch_unit;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int DL = 10;
  localparam int NI = 2;
  localparam logic [31:0] BUB = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_we;
  logic [DL-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic [NI-1:0] int_req;
  logic [NI-1:0] int_ack;
  logic [AW-1:0] epc;

  fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) fb();

  fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .N_INT(NI)) dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .int_req(int_req), .int_ack(int_ack), .epc(epc),
    .fb(fb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        stall, flush, rv;
    logic [31:0] rpc;
    logic [1:0]  irq;
    logic        ev;
    logic [31:0] ei;
    logic        el;
    logic [31:0] ep, epn;
    logic [1:0]  eack;
    logic [31:0] eepc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, f, r, input logic [31:0] rpc,
                              input logic [1:0] irq, input logic ev,
                              input logic [31:0] ei, input logic el,
                              input logic [31:0] ep, epn, input logic [1:0] eack,
                              input logic [31:0] eepc);
    vec_t v;
    v.stall = s; v.flush = f; v.rv = r; v.rpc = rpc; v.irq = irq;
    v.ev = ev; v.ei = ei; v.el = el; v.ep = ep; v.epn = epn;
    v.eack = eack; v.eepc = eepc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] ei,
                           input logic el, input logic [31:0] ep, epn,
                           input logic [1:0] eack, input logic [31:0] eepc);
    chk({tag, ".valid"},   64'(fb.if_valid),   64'(ev));
    chk({tag, ".instr"},   64'(fb.if_instr),   64'(ei));
    chk({tag, ".is_long"}, 64'(fb.if_is_long), 64'(el));
    chk({tag, ".pc"},      64'(fb.if_pc),      64'(ep));
    chk({tag, ".pc_next"}, 64'(fb.if_pc_next), 64'(epn));
    chk({tag, ".int_ack"}, 64'(int_ack),       64'(eack));
    chk({tag, ".epc"},     64'(epc),           64'(eepc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    imem_we    = 1'b1;
    imem_waddr = DL'(a);
    imem_wdata = d;
    step();
    imem_we    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; int_req = '0;
    fb.stall = 1'b0; fb.flush = 1'b0; fb.redirect_valid = 1'b0; fb.redirect_pc = '0;
    #2 reset = 1'b1;

    // ---- boot from reset vector ----
    wr(0, 16'h0000); wr(1, 16'h0020); wr(32, 16'h1111); wr(33, 16'h2222);
    check_out("rst", 1'b0, BUB, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0);
    reset = 1'b0;
    step();
    check_out("boot_e1", 1'b0, BUB, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0);
    step();
    check_out("boot_e2", 1'b1, 32'h1111_0000, 1'b0, 32'd32, 32'd33, 2'b00, 32'd0);

    // ---- main program ----
    reset = 1'b1;
    #1;
    wr(2, 16'h0000); wr(3, 16'h0200); wr(4, 16'h0000); wr(5, 16'h0300);
    wr(32, 16'hC005); wr(33, 16'hABCD); wr(34, 16'h1234);
    for (int a = 35; a <= 45; a++) wr(a, 16'h1000 + 16'(a));
    wr(100, 16'h2064); wr(101, 16'h2065);
    wr(512, 16'h3000); wr(513, 16'h3001); wr(768, 16'h3300);
    wr(1023, 16'h0AAA);

    //              st fl rv rpc            irq  v  instr          long pc            pc_next       ack   epc
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 0, BUB,          0, 0,            0,            2'b00, 0));   // 1 boot
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 0, BUB,          0, 0,            0,            2'b00, 0));   // 2 long, bubble
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'hC005ABCD, 1, 32,           34,           2'b00, 0));   // 3 IMM
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h12340000, 0, 34,           35,           2'b00, 0));   // 4
    tbl.push_back(mk(0, 0, 1, 32,           2'b00, 0, BUB,          0, 34,           35,           2'b00, 0));   // 5 redirect
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 0, BUB,          0, 34,           35,           2'b00, 0));   // 6 enter IMM
    tbl.push_back(mk(1, 0, 0, 0,            2'b00, 0, BUB,          0, 34,           35,           2'b00, 0));   // 7 stall
    tbl.push_back(mk(1, 0, 0, 0,            2'b00, 0, BUB,          0, 34,           35,           2'b00, 0));   // 8 stall
    tbl.push_back(mk(1, 0, 0, 0,            2'b00, 0, BUB,          0, 34,           35,           2'b00, 0));   // 9 stall
    tbl.push_back(mk(0, 1, 0, 0,            2'b00, 0, BUB,          0, 34,           35,           2'b00, 0));   // 10 flush in IMM
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 0, BUB,          0, 34,           35,           2'b00, 0));   // 11 refetch long
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'hC005ABCD, 1, 32,           34,           2'b00, 0));   // 12
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h12340000, 0, 34,           35,           2'b00, 0));   // 13
    tbl.push_back(mk(1, 0, 0, 0,            2'b00, 1, 32'h12340000, 0, 34,           35,           2'b00, 0));   // 14 stall valid
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h10230000, 0, 35,           36,           2'b00, 0));   // 15
    tbl.push_back(mk(1, 1, 1, 100,          2'b00, 0, BUB,          0, 35,           36,           2'b00, 0));   // 16 redirect wins
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h20640000, 0, 100,          101,          2'b00, 0));   // 17
    tbl.push_back(mk(0, 0, 1, 40,           2'b00, 0, BUB,          0, 100,          101,          2'b00, 0));   // 18
    tbl.push_back(mk(0, 0, 0, 0,            2'b11, 0, BUB,          0, 100,          101,          2'b01, 40));  // 19 ack int0
    tbl.push_back(mk(0, 1, 0, 0,            2'b00, 0, BUB,          0, 100,          101,          2'b00, 40));  // 20 INT ignores flush
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h30000000, 0, 512,          513,          2'b00, 40));  // 21 handler 0
    tbl.push_back(mk(0, 0, 0, 0,            2'b10, 0, BUB,          0, 512,          513,          2'b10, 513)); // 22 ack int1
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 0, BUB,          0, 512,          513,          2'b00, 513)); // 23
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h33000000, 0, 768,          769,          2'b00, 513)); // 24 handler 1
    tbl.push_back(mk(1, 0, 0, 0,            2'b01, 1, 32'h33000000, 0, 768,          769,          2'b00, 513)); // 25 stall blocks int
    tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 2'b00, 0, BUB,          0, 768,          769,          2'b00, 513)); // 26
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h0AAA0000, 0, 32'hFFFFFFFF, 0,            2'b00, 513)); // 27 wrap
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h00000000, 0, 0,            1,            2'b00, 513)); // 28
    tbl.push_back(mk(0, 1, 0, 0,            2'b00, 0, BUB,          0, 0,            1,            2'b00, 513)); // 29 flush in RUN
    tbl.push_back(mk(0, 0, 0, 0,            2'b00, 1, 32'h00200000, 0, 1,            2,            2'b00, 513)); // 30

    check_out("rst2", 1'b0, BUB, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0);
    reset = 1'b0;
    foreach (tbl[k]) begin
      fb.stall = tbl[k].stall; fb.flush = tbl[k].flush;
      fb.redirect_valid = tbl[k].rv; fb.redirect_pc = tbl[k].rpc;
      int_req = tbl[k].irq;
      step();
      check_out($sformatf("row%0d", k + 1), tbl[k].ev, tbl[k].ei, tbl[k].el,
                tbl[k].ep, tbl[k].epn, tbl[k].eack, tbl[k].eepc);
    end
    fb.stall = 1'b0; fb.flush = 1'b0; fb.redirect_valid = 1'b0; int_req = '0;

    // ---- asynchronous reset while a long instruction is half fetched ----
    fb.redirect_valid = 1'b1; fb.redirect_pc = 32'd32;
    step();
    fb.redirect_valid = 1'b0;
    step();
    check_out("pre_rst", 1'b0, BUB, 1'b0, 32'd1, 32'd2, 2'b00, 32'd513);
    #2 reset = 1'b1;
    #1;
    check_out("async_rst", 1'b0, BUB, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0);
    step();
    reset = 1'b0;
    step();
    check_out("reboot_e1", 1'b0, BUB, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0);
    step();
    check_out("reboot_e2", 1'b0, BUB, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0);
    step();
    check_out("reboot_e3", 1'b1, 32'hC005ABCD, 1'b1, 32'd32, 32'd34, 2'b00, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the pipelined RISC core, replacing the fixed single-word fetch. It holds the PC and an internal instruction memory. It boots from a reset vector stored in memory, assembles two-word (immediate-carrying) instructions, and vectors to interrupt handlers. It drives a registered IF/ID output with stall, flush and branch-redirect control from later stages.

## Interface
Parameters:
- DATA_W, 16, instruction word width
- ADDR_W, 32, PC width
- DEPTH_LOG2, 19, log2 of memory depth in words
- RESET_VEC_ADDR, 0, address of the two-word reset vector (high word first)
- INT_VEC_BASE, 2, address of interrupt vector 0; vector i is at INT_VEC_BASE+2*i
- N_INT, 2, number of interrupt sources
- NOP, 16'h4000, word injected on bubbles
- LONG_TAG, 2'b11, a word is the first word of a long instruction when word[DATA_W-1 -: 2] == LONG_TAG

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_we  in  1  memory write enable, for program load
- imem_waddr  in  DEPTH_LOG2  write address
- imem_wdata  in  DATA_W  write data
- stall  in  1  freeze all state and outputs
- flush  in  1  squash the current fetch
- redirect_valid  in  1  load the PC from redirect_pc; implies flush
- redirect_pc  in  ADDR_W  branch/return target
- int_req  in  N_INT  level interrupt requests; held until acknowledged
- int_ack  out  N_INT  one-hot, one-cycle acknowledge
- epc  out  ADDR_W  return address captured when int_ack pulses
- if_valid  out  1  if_instr holds a real instruction
- if_instr  out  2*DATA_W  {first word, second word}; second word is 0 for short instructions
- if_is_long  out  1  if_instr is a two-word instruction
- if_pc  out  ADDR_W  address of the first word
- if_pc_next  out  ADDR_W  address after the instruction (if_pc+1 or if_pc+2)

## Operation
- States: BOOT, RUN, IMM, INT.
- Reset values:
  - state=BOOT, pc=0, hold word=0
  - if_valid=0, if_instr={NOP,0}, if_is_long=0
  - if_pc=0, if_pc_next=0, int_ack=0, epc=0
- Memory:
  - Combinational read of mem[pc[DEPTH_LOG2-1:0]].
  - Synchronous write. A same-cycle read of the written address returns the old data.
  - The memory is not reset.
- BOOT: pc <= {mem[RESET_VEC_ADDR], mem[RESET_VEC_ADDR+1]}, truncated or zero-extended to ADDR_W. Output is a bubble. Next state is RUN.
- RUN, short word w: register if_instr={w,0}, if_valid=1, if_pc=pc, if_pc_next=pc+1. pc <= pc+1.
- RUN, long word w: hold <= w, hold_pc <= pc, pc <= pc+1. Output is a bubble. Next state is IMM.
- IMM: register if_instr={hold, mem[pc]}, if_is_long=1, if_valid=1, if_pc=hold_pc, if_pc_next=pc+1. pc <= pc+1. Next state is RUN.
- Interrupt acceptance:
  - Accepted only in RUN when not stalled, at an instruction boundary.
  - The lowest-index asserted int_req wins.
  - That cycle: int_ack=one-hot(i), epc <= pc, output is a bubble, next state is INT. pc is not advanced.
- INT: pc <= {mem[INT_VEC_BASE+2i], mem[INT_VEC_BASE+2i+1]}. Output is a bubble. Next state is RUN.
- Bubble definition: if_valid=0, if_instr={NOP,0}, if_is_long=0. if_pc and if_pc_next hold their previous values.
- Priority per edge: reset > redirect_valid > flush > stall > interrupt > normal fetch.
- redirect_valid: pc <= redirect_pc, output is a bubble, state=RUN, and any partial long fetch is discarded. Accepted in every state, including BOOT, INT and while stall is high.
- flush without redirect:
  - Output is a bubble.
  - In RUN, pc is unchanged.
  - In IMM, pc <= hold_pc and state=RUN, so the long instruction is refetched.
  - In BOOT or INT, flush is ignored and the vector load completes.
- stall (no flush or redirect): pc, state, hold and all outputs hold. int_ack is forced to 0; pending requests wait.
- Arithmetic:
  - PC increments wrap modulo 2^ADDR_W.
  - Memory indexing uses the low DEPTH_LOG2 bits, so addresses alias.
  - hold_pc+1 and pc+1 use the same wrap.

## Timing
- All outputs are registered. The word at pc appears on if_* after the next rising edge.
- After reset deasserts:
  - Edge 1: BOOT loads pc.
  - Edge 2: the first instruction is on the outputs with if_valid=1.
- Short instructions sustain one per cycle. A long instruction costs 2 cycles: one bubble, then the instruction.
- Redirect or flush: a bubble on the next edge. The target instruction is valid one edge later.
- Interrupt:
  - Ack edge: int_ack=1 for one cycle, epc valid.
  - Next edge: the INT state loads the vector.
  - The edge after that: the first handler instruction.
- Reset asserted mid-operation, including during IMM or INT: immediate return to reset values, with no partial output.

## Test plan
- Boot: mem[0]=16'h0000, mem[1]=16'h0020, mem[32]=16'h1111, reset then release. Required: pc=32 after edge 1; edge 2 gives if_instr=32'h1111_0000, if_valid=1, if_pc=32.
- Long instruction: mem[32]=16'hC005, mem[33]=16'hABCD, mem[34]=16'h1234. Required: a bubble, then if_instr=32'hC005_ABCD, if_is_long=1, if_pc=32, if_pc_next=34. Then 32'h1234_0000 with if_pc=34.
- Stall and flush during IMM: stall for 3 cycles while in IMM, then flush. Required: outputs and pc frozen during the stall; after the flush, a bubble and refetch from 32.
- Redirect vs flush vs stall: redirect_pc=100 asserted together with flush and stall. Required: a bubble, then if_pc=100; the redirect wins.
- Interrupt priority: int_req=2'b11 while pc=40, mem[2..3]=16'h0000/16'h0200. Required: int_ack=2'b01 for one cycle, epc=40, then handler fetch at if_pc=512. With int_req held at 2'b10, a later int_ack=2'b10.
- Wrap: redirect_pc=32'hFFFF_FFFF with a short word there. Required: if_pc_next=0, and the next fetch is from address 0.
